// File: rtl/instr_exec_if.sv
// Bus between the fetch stage and the execution unit: instruction in, advance
// enable out, plus accumulator/flag/status results and FSM debug visibility.
interface instr_exec_if;
    logic       ena;
    logic [7:0] instr_in;
    logic       fetch_ena;
    logic [7:0] acc_out;
    logic       flag_c;
    logic       flag_z;
    logic       done;
    logic       busy;
    logic       halted;
    logic [1:0] dbg_state;
    logic [2:0] dbg_cnt;

    // Handshake: an instruction is consumed on a rising edge where fetch_ena
    // is high; fetch_ena is combinational (ena && DECODE && out of reset), so the
    // fetch stage advances on that same edge and must hold instr_in otherwise.
    modport master (
        output ena, instr_in,
        input  fetch_ena, acc_out, flag_c, flag_z, done, busy, halted,
        input  dbg_state, dbg_cnt
    );

    modport slave (
        input  ena, instr_in,
        output fetch_ena, acc_out, flag_c, flag_z, done, busy, halted,
        output dbg_state, dbg_cnt
    );
endinterface

// File: rtl/instr_exec.sv
// 8-bit accumulator execution unit: single-cycle ALU ops, 5-iteration
// shift-add multiply, and a terminal HALT state that stalls fetch until reset.
module instr_exec (
    input  logic          clock,
    input  logic          reset_n,
    instr_exec_if.slave   bus
);
    typedef enum logic [1:0] {
        S_DECODE = 2'd0,
        S_MUL    = 2'd1,
        S_HALT   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [12:0] prod_q, prod_d;
    logic [4:0]  mop_q, mop_d;
    logic [7:0]  acc_q, acc_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic        done_q, done_d;

    logic [7:0]  operand;
    logic [8:0]  sum9;
    logic [12:0] partial;
    logic [12:0] prod_next;

    assign operand   = {3'b000, bus.instr_in[4:0]};
    assign sum9      = {1'b0, acc_q} + {1'b0, operand};
    // The multiplicand stays in acc_q for the whole multiply; it is only overwritten on completion.
    assign partial   = {5'b0_0000, acc_q} << cnt_q;
    assign prod_next = prod_q + (mop_q[cnt_q] ? partial : 13'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mop_d   = mop_q;
        acc_d   = acc_q;
        c_d     = c_q;
        z_d     = z_q;
        done_d  = 1'b0;
        if (bus.ena) begin
            unique case (state_q)
                S_DECODE: begin
                    done_d = 1'b1;
                    c_d    = 1'b0;
                    unique case (bus.instr_in[7:5])
                        3'b000: begin
                            acc_d = sum9[7:0];
                            c_d   = sum9[8];
                        end
                        3'b001: begin
                            acc_d = acc_q - operand;
                            c_d   = (operand > acc_q);
                        end
                        3'b010: begin
                            mop_d   = bus.instr_in[4:0];
                            prod_d  = 13'd0;
                            cnt_d   = 3'd0;
                            state_d = S_MUL;
                            done_d  = 1'b0;
                            c_d     = c_q;
                        end
                        3'b011:  acc_d = acc_q & operand;
                        3'b100:  acc_d = acc_q | operand;
                        3'b101:  acc_d = acc_q ^ operand;
                        3'b110:  acc_d = operand;
                        default: begin
                            state_d = S_HALT;
                            c_d     = c_q;
                        end
                    endcase
                    if (bus.instr_in[7:5] != 3'b010 && bus.instr_in[7:5] != 3'b111) begin
                        z_d = (acc_d == 8'd0);
                    end
                end
                S_MUL: begin
                    if (cnt_q == 3'd4) begin
                        acc_d   = prod_next[7:0];
                        c_d     = |prod_next[12:8];
                        z_d     = (prod_next[7:0] == 8'd0);
                        prod_d  = prod_next;
                        cnt_d   = 3'd0;
                        state_d = S_DECODE;
                        done_d  = 1'b1;
                    end else begin
                        prod_d = prod_next;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_DECODE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_DECODE;
            cnt_q   <= 3'd0;
            prod_q  <= 13'd0;
            mop_q   <= 5'd0;
            acc_q   <= 8'd0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mop_q   <= mop_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    // reset_n is folded in so fetch never advances while the unit is held in reset.
    assign bus.fetch_ena = bus.ena & reset_n & (state_q == S_DECODE);
    assign bus.acc_out   = acc_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_z    = z_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == S_MUL);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt_q;
endmodule

// File: tb/tb_instr_exec.sv
// Directed-vector bench for instr_exec: ALU ops, multiply timing/stall,
// mid-multiply reset and HALT, with hand-computed expected results.
module tb_instr_exec;
    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    int   done_cnt;
    int   busy_cnt;

    instr_exec_if bus ();

    instr_exec dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {acc, c, z, done, busy, halted, fetch_ena}
    function automatic logic [13:0] obs();
        return {bus.acc_out, bus.flag_c, bus.flag_z, bus.done, bus.busy, bus.halted, bus.fetch_ena};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cnt++;
    endtask

    task automatic drive(input logic [7:0] w);
        bus.ena      = 1'b1;
        bus.instr_in = w;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n  = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(8'h03);
        #12;
        n_cmp++;
        if (obs() !== 14'b0 || bus.dbg_state !== 2'd0 || bus.dbg_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h st %0d cnt %0d, want 0000 st 0 cnt 0", obs(), bus.dbg_state, bus.dbg_cnt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== {8'h00, 6'b000001}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs(), {8'h00, 6'b000001});
        end
    endtask

    task automatic test_stream();
        do_reset();
        drive(8'h03); step();
        n_cmp++;
        if (obs() !== {8'h03, 6'b001001}) begin
            n_fail++; $display("FAIL stream_add: got %h want %h", obs(), {8'h03, 6'b001001});
        end
        drive(8'h22); step();
        n_cmp++;
        if (obs() !== {8'h01, 6'b001001}) begin
            n_fail++; $display("FAIL stream_sub: got %h want %h", obs(), {8'h01, 6'b001001});
        end
        drive(8'h45); step();
        bus.instr_in = 8'hFF;
        n_cmp++;
        if (obs() !== {8'h01, 6'b000100}) begin
            n_fail++; $display("FAIL stream_mul_consume: got %h want %h", obs(), {8'h01, 6'b000100});
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (obs() !== {8'h01, 6'b000100}) begin
                n_fail++; $display("FAIL stream_mul_busy%0d: got %h want %h", i, obs(), {8'h01, 6'b000100});
            end
        end
        step();
        n_cmp++;
        if (obs() !== {8'h05, 6'b001001}) begin
            n_fail++; $display("FAIL stream_mul_result: got %h want %h", obs(), {8'h05, 6'b001001});
        end
        drive(8'h00); step();
        n_cmp++;
        if (obs() !== {8'h05, 6'b001001}) begin
            n_fail++; $display("FAIL stream_nop: got %h want %h", obs(), {8'h05, 6'b001001});
        end
        n_cmp++;
        if (done_cnt !== 4 || busy_cnt !== 5) begin
            n_fail++; $display("FAIL stream_counts: done %0d busy %0d, want done 4 busy 5", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_mul_overflow();
        do_reset();
        drive(8'hDF); step();
        drive(8'h5F); step();
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (obs() !== {8'hC1, 6'b101001}) begin
            n_fail++; $display("FAIL mul_overflow: got %h want %h", obs(), {8'hC1, 6'b101001});
        end
    endtask

    task automatic test_sub_borrow();
        do_reset();
        drive(8'hC1); step();
        drive(8'h22); step();
        n_cmp++;
        if (obs() !== {8'hFF, 6'b101001}) begin
            n_fail++; $display("FAIL sub_borrow: got %h want %h", obs(), {8'hFF, 6'b101001});
        end
        drive(8'h01); step();
        n_cmp++;
        if (obs() !== {8'h00, 6'b111001}) begin
            n_fail++; $display("FAIL add_wrap: got %h want %h", obs(), {8'h00, 6'b111001});
        end
        drive(8'h00); step();
        n_cmp++;
        if (obs() !== {8'h00, 6'b011001}) begin
            n_fail++; $display("FAIL nop_clears_c: got %h want %h", obs(), {8'h00, 6'b011001});
        end
    endtask

    task automatic test_logic();
        do_reset();
        drive(8'hCC); step();
        drive(8'h6A); step();
        n_cmp++;
        if (obs() !== {8'h08, 6'b001001}) begin
            n_fail++; $display("FAIL and_op: got %h want %h", obs(), {8'h08, 6'b001001});
        end
        drive(8'h83); step();
        n_cmp++;
        if (obs() !== {8'h0B, 6'b001001}) begin
            n_fail++; $display("FAIL or_op: got %h want %h", obs(), {8'h0B, 6'b001001});
        end
        drive(8'hAB); step();
        n_cmp++;
        if (obs() !== {8'h00, 6'b011001}) begin
            n_fail++; $display("FAIL xor_op: got %h want %h", obs(), {8'h00, 6'b011001});
        end
    endtask

    task automatic test_ena_low();
        do_reset();
        drive(8'hC5); step();
        bus.ena = 1'b0;
        bus.instr_in = 8'h01;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs() !== {8'h05, 6'b000000}) begin
                n_fail++; $display("FAIL ena_low%0d: got %h want %h", i, obs(), {8'h05, 6'b000000});
            end
        end
        bus.ena = 1'b1;
        step();
        n_cmp++;
        if (obs() !== {8'h06, 6'b001001}) begin
            n_fail++; $display("FAIL ena_resume: got %h want %h", obs(), {8'h06, 6'b001001});
        end
    endtask

    task automatic test_mul_stall();
        do_reset();
        drive(8'hC3); step();
        drive(8'h46); step();
        step(); step();
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs() !== {8'h03, 6'b000100} || bus.dbg_cnt !== 3'd2) begin
                n_fail++; $display("FAIL mul_stall%0d: got %h cnt %0d want %h cnt 2", i, obs(), bus.dbg_cnt, {8'h03, 6'b000100});
            end
        end
        bus.ena = 1'b1;
        step(); step(); step();
        n_cmp++;
        if (obs() !== {8'h12, 6'b001001}) begin
            n_fail++; $display("FAIL mul_stall_result: got %h want %h", obs(), {8'h12, 6'b001001});
        end
        n_cmp++;
        if (busy_cnt !== 8) begin
            n_fail++; $display("FAIL mul_stall_busy: got %0d want 8", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        drive(8'hC5); step();
        drive(8'h43); step();
        step(); step();
        done_cnt = 0;
        bus.instr_in = 8'hC7;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 14'b0 || bus.dbg_state !== 2'd0 || bus.dbg_cnt !== 3'd0) begin
            n_fail++; $display("FAIL mid_mul_reset: got %h st %0d cnt %0d want 0000 st 0 cnt 0", obs(), bus.dbg_state, bus.dbg_cnt);
        end
        #2 reset_n = 1'b1;
        step();
        n_cmp++;
        if (obs() !== {8'h07, 6'b001001} || done_cnt !== 1) begin
            n_fail++; $display("FAIL after_mid_reset: got %h done %0d want %h done 1", obs(), done_cnt, {8'h07, 6'b001001});
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(8'hC9); step();
        drive(8'hE0); step();
        n_cmp++;
        if ({bus.acc_out, bus.busy, bus.halted, bus.fetch_ena} !== {8'h09, 3'b010} || bus.dbg_state !== 2'd2) begin
            n_fail++; $display("FAIL halt_enter: got %h st %0d want %h st 2", {bus.acc_out, bus.busy, bus.halted, bus.fetch_ena}, bus.dbg_state, {8'h09, 3'b010});
        end
        drive(8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs() !== {8'h09, 6'b000010}) begin
                n_fail++; $display("FAIL halt_frozen%0d: got %h want %h", i, obs(), {8'h09, 6'b000010});
            end
        end
        do_reset();
        #1;
        n_cmp++;
        if (obs() !== {8'h00, 6'b000001}) begin
            n_fail++; $display("FAIL halt_reset: got %h want %h", obs(), {8'h00, 6'b000001});
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        reset_n  = 1'b0;
        bus.ena      = 1'b0;
        bus.instr_in = 8'h00;
        test_reset();
        test_stream();
        test_mul_overflow();
        test_sub_borrow();
        test_logic();
        test_ena_low();
        test_mul_stall();
        test_reset_mid_mul();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
